// File: rtl/uart_link_pkg.sv
// Shared types and helpers for the UART link blocks.
package uart_link_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_SIZE  = 16;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        COMMIT
    } loader_state_t;

    // XOR of every byte in a default-sized flattened frame.
    function automatic logic [DEFAULT_WIDTH-1:0] xor_reduce_bytes(
        input logic [DEFAULT_WIDTH*DEFAULT_SIZE-1:0] data
    );
        logic [DEFAULT_WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(DEFAULT_SIZE); i++) begin
            acc ^= data[DEFAULT_WIDTH*i +: DEFAULT_WIDTH];
        end
        return acc;
    endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Idle-cycle watchdog: counts enabled cycles without a clear, flags the cycle the count reaches CYCLES.
module frame_timeout_counter #(
    parameter int unsigned CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_c_o
);

    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // High in the cycle whose closing edge would bring the count to CYCLES.
    assign tc_c_o = en_i && !clr_i && (cnt_q == CNT_W'(CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i || !en_i || tc_c_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Rebuilds a checksum-validated SIZE x WIDTH register frame from a UART byte stream
// and publishes it atomically in the pattern-generator flattened layout.
module uart_frame_loader
    import uart_link_pkg::*;
#(
    parameter int unsigned      WIDTH          = 8,
    parameter int unsigned      SIZE           = 16,
    parameter logic [WIDTH-1:0] SYNC_BYTE      = WIDTH'(DEFAULT_SYNC_BYTE),
    parameter int unsigned      TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [WIDTH*SIZE-1:0] frame_out,
    output logic                  frame_valid,
    output logic                  err_checksum,
    output logic                  err_timeout,
    output logic                  busy
);

    localparam int unsigned IDX_W  = $clog2(SIZE + 1);
    localparam int unsigned SLOT_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    loader_state_t                state_q;
    logic [SIZE-1:0][WIDTH-1:0]   shadow_q;
    logic [SIZE-1:0][WIDTH-1:0]   frame_q;
    logic [IDX_W-1:0]             idx_q;
    logic [WIDTH-1:0]             acc_q;
    logic                         rx_ready_q;
    logic                         busy_q;
    logic                         frame_valid_q;
    logic                         err_checksum_q;
    logic                         err_timeout_q;

    logic                         accept_c;
    logic                         cnt_en_c;
    logic                         timeout_c;

    assign accept_c = rx_valid && rx_ready_q;
    assign cnt_en_c = (state_q == LOAD) || (state_q == CHECK);

    frame_timeout_counter #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (cnt_en_c),
        .clr_i  (accept_c),
        .tc_c_o (timeout_c)
    );

    // Frame FSM; an accepted byte always takes priority over an expiring timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            shadow_q       <= '0;
            frame_q        <= '0;
            idx_q          <= '0;
            acc_q          <= '0;
            rx_ready_q     <= 1'b1;
            busy_q         <= 1'b0;
            frame_valid_q  <= 1'b0;
            err_checksum_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            frame_valid_q  <= 1'b0;
            err_checksum_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c && (rx_data == SYNC_BYTE)) begin
                        state_q <= LOAD;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept_c) begin
                        shadow_q[idx_q[SLOT_W-1:0]] <= rx_data;
                        acc_q <= acc_q ^ rx_data;
                        idx_q <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(SIZE - 1)) begin
                            state_q <= CHECK;
                        end
                    end else if (timeout_c) begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        err_timeout_q <= 1'b1;
                    end
                end
                CHECK: begin
                    if (accept_c) begin
                        if (rx_data == acc_q) begin
                            state_q    <= COMMIT;
                            rx_ready_q <= 1'b0;
                        end else begin
                            state_q        <= IDLE;
                            busy_q         <= 1'b0;
                            err_checksum_q <= 1'b1;
                        end
                    end else if (timeout_c) begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        err_timeout_q <= 1'b1;
                    end
                end
                COMMIT: begin
                    frame_q       <= shadow_q;
                    frame_valid_q <= 1'b1;
                    state_q       <= IDLE;
                    busy_q        <= 1'b0;
                    rx_ready_q    <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    rx_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_q;
    assign frame_out    = frame_q;
    assign frame_valid  = frame_valid_q;
    assign err_checksum = err_checksum_q;
    assign err_timeout  = err_timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: frame vector table plus multi-cycle corner sequences.
module tb_uart_frame_loader;
    import uart_link_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 16;
    localparam int unsigned TO = 50;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   rx_data = '0;
    logic           rx_valid = 1'b0;
    logic           rx_ready;
    logic [W*N-1:0] frame_out;
    logic           frame_valid;
    logic           err_checksum;
    logic           err_timeout;
    logic           busy;

    always #5 clk = ~clk;

    uart_frame_loader #(
        .WIDTH          (W),
        .SIZE           (N),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .frame_out    (frame_out),
        .frame_valid  (frame_valid),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout),
        .busy         (busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    int n_valid    = 0;
    int n_cerr     = 0;
    int n_terr     = 0;
    int n_overlap  = 0;
    int n_notready = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            n_valid    += int'(frame_valid);
            n_cerr     += int'(err_checksum);
            n_terr     += int'(err_timeout);
            n_notready += int'(!rx_ready);
            if (int'(frame_valid) + int'(err_checksum) + int'(err_timeout) > 1) n_overlap++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_byte_stall: rx_ready low for %0d cycles, required at most 1", guard);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [127:0] p, input logic [7:0] cs);
        send_byte(8'hA5);
        for (int i = 0; i < int'(N); i++) send_byte(p[8*i +: 8]);
        send_byte(cs);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic         junk;
        logic [127:0] payload;
        logic [7:0]   csum;
        int           exp_valid;
        int           exp_cerr;
        logic [127:0] exp_frame;
    } vec_t;

    vec_t         vecs[5];
    logic [127:0] p_inc, p_a5, p_one, p_mul3, p_alt;

    initial begin
        int b_valid, b_cerr, b_terr, b_nr, k;

        for (int i = 0; i < int'(N); i++) begin
            p_inc[8*i +: 8]  = 8'(i + 1);
            p_a5[8*i +: 8]   = 8'hA5;
            p_mul3[8*i +: 8] = 8'(3 * i + 7);
            p_alt[8*i +: 8]  = 8'(8'hF0 - i);
        end
        p_one = '0;
        p_one[8*5 +: 8] = 8'h3C;

        vecs[0] = '{1'b0, p_inc, 8'h10, 1, 0, p_inc};
        vecs[1] = '{1'b0, p_inc, 8'h00, 0, 1, p_inc};
        vecs[2] = '{1'b1, p_a5,  8'h00, 1, 0, p_a5};
        vecs[3] = '{1'b0, p_one, 8'h3C, 1, 0, p_one};
        vecs[4] = '{1'b0, p_inc, 8'h11, 0, 1, p_one};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_frame_out", frame_out, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_pulses", {frame_valid, err_checksum, err_timeout}, 3'b000);
        rst_n = 1'b1;
        idle(2);

        // Good frame with latency and busy/ready detail
        send_byte(8'hA5);
        check("busy_after_sync", busy, 1'b1);
        for (int i = 0; i < int'(N); i++) send_byte(p_inc[8*i +: 8]);
        send_byte(8'h10);
        check("commit_busy", busy, 1'b1);
        check("commit_rx_ready", rx_ready, 1'b0);
        check("commit_no_valid_yet", frame_valid, 1'b0);
        check("commit_frame_unchanged", frame_out, '0);
        idle(1);
        check("publish_valid", frame_valid, 1'b1);
        check("publish_busy", busy, 1'b0);
        check("publish_reg0", frame_out[7:0], 8'h01);
        check("publish_reg15", frame_out[127:120], 8'h10);
        idle(1);
        check("publish_valid_one_cycle", frame_valid, 1'b0);

        // Frame vector table
        for (int v = 0; v < 5; v++) begin
            b_valid = n_valid; b_cerr = n_cerr; b_terr = n_terr;
            if (vecs[v].junk) begin
                send_byte(8'h00);
                send_byte(8'hFF);
                check($sformatf("v%0d_junk_ignored", v), busy, 1'b0);
            end
            send_frame(vecs[v].payload, vecs[v].csum);
            idle(3);
            check($sformatf("v%0d_valid_pulses", v), 128'(n_valid - b_valid), 128'(vecs[v].exp_valid));
            check($sformatf("v%0d_cerr_pulses", v), 128'(n_cerr - b_cerr), 128'(vecs[v].exp_cerr));
            check($sformatf("v%0d_terr_pulses", v), 128'(n_terr - b_terr), 128'd0);
            check($sformatf("v%0d_frame_out", v), frame_out, vecs[v].exp_frame);
            check($sformatf("v%0d_busy", v), busy, 1'b0);
        end

        // Timeout after 5 payload bytes
        b_valid = n_valid;
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_byte(p_inc[8*i +: 8]);
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (err_timeout) break;
        end
        check("timeout_cycle", 128'(k), 128'(TO));
        check("timeout_busy", busy, 1'b0);
        check("timeout_frame_kept", frame_out, p_one);
        idle(1);
        check("timeout_one_cycle", err_timeout, 1'b0);
        check("timeout_no_valid", 128'(n_valid - b_valid), 128'd0);
        send_frame(p_mul3, xor_reduce_bytes(p_mul3));
        idle(2);
        check("after_timeout_frame", frame_out, p_mul3);

        // Byte arrives on the very cycle the count expires: byte wins
        b_valid = n_valid; b_terr = n_terr;
        send_byte(8'hA5);
        send_byte(p_alt[7:0]);
        idle(int'(TO) - 1);
        for (int i = 1; i < int'(N); i++) send_byte(p_alt[8*i +: 8]);
        send_byte(xor_reduce_bytes(p_alt));
        idle(3);
        check("race_no_timeout", 128'(n_terr - b_terr), 128'd0);
        check("race_valid", 128'(n_valid - b_valid), 128'd1);
        check("race_frame", frame_out, p_alt);

        // Back-to-back frames with rx_valid held high
        b_valid = n_valid; b_nr = n_notready;
        send_frame(p_inc, 8'h10);
        send_frame(p_a5, 8'h00);
        idle(3);
        check("b2b_valid_pulses", 128'(n_valid - b_valid), 128'd2);
        check("b2b_ready_low_cycles", 128'(n_notready - b_nr), 128'd2);
        check("b2b_frame", frame_out, p_a5);

        // Reset mid-frame
        b_valid = n_valid; b_cerr = n_cerr; b_terr = n_terr;
        send_byte(8'hA5);
        for (int i = 0; i < 8; i++) send_byte(p_mul3[8*i +: 8]);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_frame_out", frame_out, '0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rx_ready", rx_ready, 1'b1);
        idle(3);
        check("midrst_no_pulses", 128'((n_valid - b_valid) + (n_cerr - b_cerr) + (n_terr - b_terr)), 128'd0);
        b_valid = n_valid;
        send_frame(p_mul3, xor_reduce_bytes(p_mul3));
        idle(2);
        check("midrst_reload_frame", frame_out, p_mul3);
        check("midrst_reload_valid", 128'(n_valid - b_valid), 128'd1);

        check("pulse_exclusive", 128'(n_overlap), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
